// File: rtl/cdc_edge_event_queue.sv
// cdc_edge_event_queue
//   Fast-domain consumer of an already-synchronised level. It tracks the accepted
//   level, emits one-cycle rise/fall pulses and timestamps each accepted edge with a
//   free-running counter. Events {kind, ts} are queued in a small FIFO that is drained
//   over a valid/ready handshake. A sticky flag records any event dropped on a full FIFO.
//
//   Optional feature: define CDC_GLITCH_FILTER_EN to accept an edge only after
//   FILT_CYC consecutive samples differ from the accepted level.
//
// Ports
//   clk_i        in   1     clock, all logic on posedge
//   rst_ni       in   1     synchronous active-low reset
//   data_i       in   1     synchronised input level
//   level_o      out  1     accepted level
//   rise_o       out  1     one-cycle pulse per accepted rising edge
//   fall_o       out  1     one-cycle pulse per accepted falling edge
//   evt_valid_o  out  1     event FIFO non-empty
//   evt_ready_i  in   1     consumer pops head event when high with evt_valid_o
//   evt_kind_o   out  1     head event kind (1 = rise, 0 = fall)
//   evt_ts_o     out  TS_W  head event timestamp
//   overflow_o   out  1     sticky: an event was dropped on a full FIFO
//   clr_ovf_i    in   1     clears overflow_o (a simultaneous drop wins)

module cdc_edge_event_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned TS_W     = 16,
    parameter int unsigned FILT_CYC = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            data_i,
    output logic            level_o,
    output logic            rise_o,
    output logic            fall_o,
    output logic            evt_valid_o,
    input  logic            evt_ready_i,
    output logic            evt_kind_o,
    output logic [TS_W-1:0] evt_ts_o,
    output logic            overflow_o,
    input  logic            clr_ovf_i
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = TS_W + 1;

    // Elaboration-time parameter sanity check
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (FILT_CYC < 1)) begin : g_param_check
        $error("cdc_edge_event_queue: DEPTH must be a power of 2 >= 2 and FILT_CYC >= 1");
    end

    logic              init_q, init_d;
    logic              level_q, level_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [ENT_W-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              valid_q, valid_d;
    logic              kind_q, kind_d;
    logic [TS_W-1:0]   head_ts_q, head_ts_d;

    logic              accept;
    logic              pop;
    logic              full;
    logic              push_ok;
    logic              drop;

`ifdef CDC_GLITCH_FILTER_EN
    localparam int unsigned FLT_W = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
    logic [FLT_W-1:0]  flt_cnt_q, flt_cnt_d;
`endif

    // Level tracking, edge acceptance and pulse generation
    always_comb begin
        init_d  = init_q;
        level_d = level_q;
        accept  = 1'b0;
`ifdef CDC_GLITCH_FILTER_EN
        flt_cnt_d = flt_cnt_q;
`endif
        if (!init_q) begin
            // First sample after reset only establishes the reference level
            init_d  = 1'b1;
            level_d = data_i;
        end else if (data_i != level_q) begin
`ifdef CDC_GLITCH_FILTER_EN
            if (flt_cnt_q == FLT_W'(FILT_CYC - 1)) begin
                accept    = 1'b1;
                flt_cnt_d = '0;
            end else begin
                flt_cnt_d = flt_cnt_q + FLT_W'(1);
            end
`else
            accept = 1'b1;
`endif
        end else begin
`ifdef CDC_GLITCH_FILTER_EN
            flt_cnt_d = '0;
`endif
        end
        if (accept) begin
            level_d = data_i;
        end
        rise_d = accept & data_i;
        fall_d = accept & ~data_i;
        ts_d   = ts_q + TS_W'(1);
    end

    // Event FIFO; head outputs are registered from the next-state view of the FIFO
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;

        pop     = (cnt_q != '0) && evt_ready_i;
        full    = (cnt_q == CNT_W'(DEPTH));
        push_ok = accept && (!full || pop);
        drop    = accept && full && !pop;

        // When full, wr_ptr == rd_ptr; with a pop the freed head slot becomes the tail
        if (push_ok) begin
            mem_d[wr_ptr_q] = {data_i, ts_q};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        valid_d               = (cnt_d != '0);
        {kind_d, head_ts_d}   = mem_d[rd_ptr_d];
        ovf_d                 = drop | (ovf_q & ~clr_ovf_i);
    end

    // State registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            init_q    <= 1'b0;
            level_q   <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            ts_q      <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            kind_q    <= 1'b0;
            head_ts_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
`ifdef CDC_GLITCH_FILTER_EN
            flt_cnt_q <= '0;
`endif
        end else begin
            init_q    <= init_d;
            level_q   <= level_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            ts_q      <= ts_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            kind_q    <= kind_d;
            head_ts_q <= head_ts_d;
            mem_q     <= mem_d;
`ifdef CDC_GLITCH_FILTER_EN
            flt_cnt_q <= flt_cnt_d;
`endif
        end
    end

    assign level_o     = level_q;
    assign rise_o      = rise_q;
    assign fall_o      = fall_q;
    assign evt_valid_o = valid_q;
    assign evt_kind_o  = kind_q;
    assign evt_ts_o    = head_ts_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_cdc_edge_event_queue.sv
// Testbench for cdc_edge_event_queue: directed scenarios with literal expectations,
// then randomized stimulus checked every cycle against a queue-based behavioural model.
module tb_cdc_edge_event_queue;

    localparam int DEPTH = 4;
    localparam int TS_W  = 4;
    localparam int FILT  = 2;
`ifdef CDC_GLITCH_FILTER_EN
    localparam int EFF_FILT = FILT;
`else
    localparam int EFF_FILT = 1;
`endif
    localparam int FILT_ON = (EFF_FILT > 1) ? 1 : 0;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            data;
    logic            ready;
    logic            clr;
    logic            level_o, rise_o, fall_o, evt_valid_o, evt_kind_o, overflow_o;
    logic [TS_W-1:0] evt_ts_o;

    int checks = 0;
    int errors = 0;

    cdc_edge_event_queue #(.DEPTH(DEPTH), .TS_W(TS_W), .FILT_CYC(FILT)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .data_i      (data),
        .level_o     (level_o),
        .rise_o      (rise_o),
        .fall_o      (fall_o),
        .evt_valid_o (evt_valid_o),
        .evt_ready_i (ready),
        .evt_kind_o  (evt_kind_o),
        .evt_ts_o    (evt_ts_o),
        .overflow_o  (overflow_o),
        .clr_ovf_i   (clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: state after each rising clock edge
    logic [TS_W:0] mq[$];
    int  m_ts    = 0;
    int  m_run   = 0;
    bit  m_init  = 0;
    bit  m_level = 0;
    bit  m_rise  = 0;
    bit  m_fall  = 0;
    bit  m_ovf   = 0;
    bit  m_rst   = 0;
    bit  m_live  = 0;

    always @(posedge clk) begin
        bit acc, pop, full;
        m_live = 1;
        if (!rst_n) begin
            mq.delete();
            m_ts = 0; m_run = 0; m_init = 0; m_level = 0;
            m_rise = 0; m_fall = 0; m_ovf = 0; m_rst = 1;
        end else begin
            m_rst = 0;
            acc   = 0;
            pop   = (mq.size() != 0) && ready;
            full  = (mq.size() == DEPTH);
            if (!m_init) begin
                m_init  = 1;
                m_level = data;
            end else if (data != m_level) begin
                m_run++;
                if (m_run >= EFF_FILT) acc = 1;
            end else begin
                m_run = 0;
            end
            m_rise = acc && data;
            m_fall = acc && !data;
            if (pop) void'(mq.pop_front());
            if (acc) begin
                m_level = data;
                m_run   = 0;
                if (!(full && !pop)) mq.push_back({data, TS_W'(m_ts)});
            end
            if (acc && full && !pop) m_ovf = 1;
            else if (clr)            m_ovf = 0;
            m_ts = (m_ts + 1) % (1 << TS_W);
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (m_live) begin
            chk("level", int'(level_o), int'(m_level));
            chk("rise", int'(rise_o), int'(m_rise));
            chk("fall", int'(fall_o), int'(m_fall));
            chk("valid", int'(evt_valid_o), (mq.size() != 0) ? 1 : 0);
            chk("overflow", int'(overflow_o), int'(m_ovf));
            if (mq.size() != 0) begin
                chk("head_kind", int'(evt_kind_o), int'(mq[0][TS_W]));
                chk("head_ts", int'(evt_ts_o), int'(mq[0][TS_W-1:0]));
            end else if (m_rst) begin
                chk("rst_kind", int'(evt_kind_o), 0);
                chk("rst_ts", int'(evt_ts_o), 0);
            end
        end
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; data = 1'b1; ready = 1'b0; clr = 1'b0;
        repeat (3) nxt();
        chk("L_rst_valid", int'(evt_valid_o), 0);
        chk("L_rst_ovf", int'(overflow_o), 0);
        chk("L_rst_level", int'(level_o), 0);
        chk("L_rst_ts", int'(evt_ts_o), 0);

        // Data high through reset: init edge loads level, no rise
        rst_n = 1'b1;
        nxt();
        chk("L_init_level", int'(level_o), 1);
        chk("L_init_rise", int'(rise_o), 0);
        chk("L_init_valid", int'(evt_valid_o), 0);
        data = 1'b0; ready = 1'b1;
        nxt();
        chk("L_fall1", int'(fall_o), 1);
        chk("L_fall1_kind", int'(evt_kind_o), 0);
        chk("L_fall1_ts", int'(evt_ts_o), 1);
        nxt();
        chk("L_pop1_valid", int'(evt_valid_o), 0);
        nxt();
        nxt();
        data = 1'b1;
        nxt();
        chk("L_rise_ts5", int'(evt_ts_o), 5);
        chk("L_rise_kind", int'(evt_kind_o), 1);
        chk("L_rise_pulse", int'(rise_o), 1);
        nxt();
        chk("L_rise_popped", int'(evt_valid_o), 0);
        chk("L_rise_pulse_end", int'(rise_o), 0);

        // Five toggles with consumer stalled: fifth dropped
        ready = 1'b0; data = 1'b0;
        nxt(); data = 1'b1;
        nxt(); data = 1'b0;
        nxt(); data = 1'b1;
        nxt(); data = 1'b0;
        nxt();
        chk("L_ovf_set", int'(overflow_o), 1);
        chk("L_ovf_pulse", int'(fall_o), 1);
        chk("L_ovf_head_ts", int'(evt_ts_o), 7);
        clr = 1'b1;
        nxt();
        chk("L_ovf_clr", int'(overflow_o), 0);
        clr = 1'b0; data = 1'b1; ready = 1'b1;
        nxt();
        chk("L_full_pushpop_ovf", int'(overflow_o), 0);
        chk("L_full_pushpop_ts", int'(evt_ts_o), 8);
        nxt();
        chk("L_drain_ts9", int'(evt_ts_o), 9);
        data = 1'b0;
        nxt();
        chk("L_drain_ts10", int'(evt_ts_o), 10);
        data = 1'b1;
        nxt();
        chk("L_drain_ts13", int'(evt_ts_o), 13);
        nxt();
        chk("L_wrap_ts15", int'(evt_ts_o), 15);
        chk("L_wrap_kind15", int'(evt_kind_o), 0);
        nxt();
        chk("L_wrap_ts0", int'(evt_ts_o), 0);
        chk("L_wrap_kind0", int'(evt_kind_o), 1);
        nxt();
        chk("L_drained", int'(evt_valid_o), 0);

        // One-cycle low glitch
        data = 1'b0;
        nxt();
        chk("L_glitch_fall", int'(fall_o), FILT_ON ? 0 : 1);
        chk("L_glitch_valid", int'(evt_valid_o), FILT_ON ? 0 : 1);
        data = 1'b1;
        nxt();
        chk("L_glitch_rise", int'(rise_o), FILT_ON ? 0 : 1);
        chk("L_glitch_level", int'(level_o), 1);

        // Randomized phase
        for (int c = 0; c < 3000; c++) begin
            int hold_pct;
            hold_pct = ((c / 200) % 2 == 0) ? 55 : 85;
            if ($urandom_range(0, 99) >= hold_pct) data = ~data;
            ready = ((c / 150) % 3 == 1) ? ($urandom_range(0, 9) == 0)
                                         : ($urandom_range(0, 2) != 0);
            clr   = ($urandom_range(0, 24) == 0);
            rst_n = ($urandom_range(0, 499) != 0);
            nxt();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
